// File: rtl/register_file.sv
// Architectural register file with per-register rename state (busy bit + ROB tag).
// Optional same-cycle commit forwarding on the read ports when RF_BYPASS_EN is defined.
module register_file #(
    parameter int unsigned ROB_IDX_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rdy,
    input  logic                 flush,
    input  logic [4:0]           dec_rs1_in,
    input  logic [4:0]           dec_rs2_in,
    output logic [31:0]          dec_rs1_val_out,
    output logic [31:0]          dec_rs2_val_out,
    output logic                 dec_rs1_busy_out,
    output logic                 dec_rs2_busy_out,
    output logic [ROB_IDX_W-1:0] rob_rs1_idx_out,
    output logic [ROB_IDX_W-1:0] rob_rs2_idx_out,
    input  logic                 new_flag_in,
    input  logic [ROB_IDX_W-1:0] new_idx_in,
    input  logic [4:0]           new_rd_in,
    input  logic                 write_flag_in,
    input  logic [ROB_IDX_W-1:0] write_idx_in,
    input  logic [4:0]           write_rd_in,
    input  logic [31:0]          val_in
);

    localparam int unsigned NREG   = 32;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned RIDX_W = 5;

    typedef struct packed {
        logic [XLEN-1:0]      val;
        logic                 busy;
        logic [ROB_IDX_W-1:0] tag;
    } rd_port_t;

    logic [XLEN-1:0]      regs     [NREG];
    logic [NREG-1:0]      busy;
    logic [NREG-1:0]      busy_nxt;
    logic [ROB_IDX_W-1:0] tag      [NREG];
    logic [ROB_IDX_W-1:0] tag_nxt  [NREG];

    logic commit_en_c;
    logic rename_en_c;
    logic [RIDX_W-1:0] rs_sel_c [2];

    // x0 is never a legal destination, so its state stays at the reset value forever.
    assign commit_en_c = rdy && write_flag_in && (write_rd_in != RIDX_W'(0));
    assign rename_en_c = rdy && !flush && new_flag_in && (new_rd_in != RIDX_W'(0));

    // Rename state update; rename is applied last so it wins over a same-rd commit clear.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < NREG; i++) begin
            tag_nxt[i] = tag[i];
        end
        if (flush) begin
            busy_nxt = '0;
        end else begin
            if (commit_en_c && (tag[write_rd_in] == write_idx_in)) begin
                busy_nxt[write_rd_in] = 1'b0;
            end
            if (rename_en_c) begin
                busy_nxt[new_rd_in] = 1'b1;
                tag_nxt[new_rd_in]  = new_idx_in;
            end
        end
    end

    // Commit data write happens regardless of tag match or flush.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (commit_en_c) begin
            regs[write_rd_in] <= val_in;
        end
    end

    // Busy/tag registers; tags are left untouched when busy drops, a stale tag is never consulted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= '0;
            for (int i = 0; i < NREG; i++) begin
                tag[i] <= '0;
            end
        end else if (rdy) begin
            busy <= busy_nxt;
            for (int i = 0; i < NREG; i++) begin
                tag[i] <= tag_nxt[i];
            end
        end
    end

    assign rs_sel_c[0] = dec_rs1_in;
    assign rs_sel_c[1] = dec_rs2_in;

    // Combinational read ports; a pending operand reports value 0 so nothing stale leaks out.
    for (genvar p = 0; p < 2; p++) begin : g_rd
        rd_port_t rp_c;
        always_comb begin
            rp_c.tag  = tag[rs_sel_c[p]];
            rp_c.busy = busy[rs_sel_c[p]];
            rp_c.val  = regs[rs_sel_c[p]];
`ifdef RF_BYPASS_EN
            if (rp_c.busy && write_flag_in && (write_rd_in == rs_sel_c[p])
                && (rp_c.tag == write_idx_in)) begin
                rp_c.busy = 1'b0;
                rp_c.val  = val_in;
            end
`endif
            if (rp_c.busy) begin
                rp_c.val = '0;
            end
        end
    end

    assign dec_rs1_val_out  = g_rd[0].rp_c.val;
    assign dec_rs1_busy_out = g_rd[0].rp_c.busy;
    assign rob_rs1_idx_out  = g_rd[0].rp_c.tag;
    assign dec_rs2_val_out  = g_rd[1].rp_c.val;
    assign dec_rs2_busy_out = g_rd[1].rp_c.busy;
    assign rob_rs2_idx_out  = g_rd[1].rp_c.tag;

endmodule

// File: doc/register_file.md
REGISTER_FILE -- requirements
Module: register_file

Interface
REQ-001 SHALL have parameter ROB_IDX_W, default 4, giving the ROB tag width (16 ROB entries).
REQ-002 SHALL have port clk, input, 1, the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, the reset: asynchronous, active-low.
REQ-004 SHALL have port rdy, input, 1, global ready; when low, no architectural state changes.
REQ-005 SHALL have port flush, input, 1, the ROB mispredict recovery (jump_wrong).
REQ-006 SHALL have ports dec_rs1_in and dec_rs2_in, input, 5 each, the decoder source register indices.
REQ-007 SHALL have ports dec_rs1_val_out and dec_rs2_val_out, output, 32 each, the source operand values.
REQ-008 SHALL have ports dec_rs1_busy_out and dec_rs2_busy_out, output, 1 each; high means the operand is pending in the ROB.
REQ-009 SHALL have ports rob_rs1_idx_out and rob_rs2_idx_out, output, ROB_IDX_W each, the rename tags used by the ROB for its operand lookup.
REQ-010 SHALL have ports new_flag_in (1), new_idx_in (ROB_IDX_W) and new_rd_in (5), input, the rename request from the ROB at issue.
REQ-011 SHALL have ports write_flag_in (1), write_idx_in (ROB_IDX_W), write_rd_in (5) and val_in (32), input, the commit write from the ROB head.

Function
REQ-012 SHALL hold 32 x 32-bit registers, plus a busy bit and a ROB_IDX_W-bit tag per register.
REQ-013 SHALL hardwire x0: reads return 0 with busy=0, and writes and renames to x0 are ignored.
REQ-014 SHALL make all read ports purely combinational (zero latency), whatever the state of rdy.
REQ-015 SHALL drive rob_rsN_idx_out with tag[dec_rsN_in] at all times.
REQ-016 SHALL drive dec_rsN_val_out with the register value when the source is not busy, and with don't-care (0) when it is busy.
REQ-017 SHALL, on commit (write_flag_in=1, write_rd_in!=0, rdy=1), write regs[write_rd_in] <= val_in at the clock edge, unconditionally.
REQ-018 SHALL, on commit, clear busy[rd] only if tag[rd]==write_idx_in; a younger pending writer keeps the register busy.
REQ-019 SHALL, on rename (new_flag_in=1, new_rd_in!=0, rdy=1, flush=0), set busy[new_rd_in] <= 1 and tag <= new_idx_in.
REQ-020 SHALL give rename priority over the commit busy-clear when both target the same rd in the same cycle; the register ends busy with new_idx_in.
REQ-021 SHALL, when flush=1 and rdy=1, clear all 32 busy bits, ignore rename, and still perform the commit data write.
REQ-022 SHALL change no state when rdy=0, including flush, rename and commit.
REQ-023 SHALL keep the tag unchanged when busy is cleared, so a stale tag is harmless.

Reset
REQ-024 SHALL, while rst_n=0, asynchronously clear all registers to 0, all busy bits to 0 and all tags to 0.
REQ-025 SHALL present, during reset, all read outputs as value 0, busy 0 and tag 0.
REQ-026 SHALL abandon any in-flight rename or commit when reset is asserted mid-cycle, and commit nothing.
REQ-027 SHALL leave reset synchronously to clk; the first update occurs on the first rising edge with rst_n=1.

Configuration
REQ-028 SHALL implement same-cycle commit bypass when macro RF_BYPASS_EN is defined.
REQ-029 SHALL, with RF_BYPASS_EN defined, treat dec_rsN_in as resolved in the commit cycle when it is busy, write_flag_in=1, write_rd_in==dec_rsN_in and tag==write_idx_in, outputting busy=0 and val=val_in.
REQ-030 SHALL, with RF_BYPASS_EN undefined, apply no forwarding: reads reflect stored state only, and the issuer obtains the value from the ROB ready path.

Verification
REQ-031 SHALL cover: reset, then read x5 -> val 0, busy 0, tag 0.
REQ-032 SHALL cover: rename x5 tag 3, then commit x5 idx 3 val 0xDEADBEEF -> next cycle x5 = 0xDEADBEEF, busy 0.
REQ-033 SHALL cover: rename x7 tag 2, then tag 4, then commit x7 idx 2 val 0x11 -> x7 = 0x11, busy stays 1, tag 4.
REQ-034 SHALL cover: same cycle, commit x9 idx 1 and rename x9 tag 6 -> x9 busy 1, tag 6, value updated.
REQ-035 SHALL cover: x3 and x4 busy; flush with rename x8 tag 5 -> all busy 0 and x8 not renamed.
REQ-036 SHALL cover: with RF_BYPASS_EN, x2 busy tag 1 and commit x2 idx 1 val 0x42 -> same cycle dec_rs1 (x2) val 0x42, busy 0; without the macro -> busy 1, tag 1.
